add_seq: RTL

//   Multi-cycle, chunk-serial adder/subtractor. Processes CHUNK bits per clock, LSB chunk first.

---
 rtl/add_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/add_seq.sv
// add_seq: multi-cycle chunk-serial adder/subtractor.
//   Adds CHUNK bits per clock, LSB chunk first, so the carry chain per cycle is only
//   CHUNK+1 bits long. N = WIDTH/CHUNK chunk cycles plus one commit cycle per operation.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, accepted in IDLE or DONE only
//   sub    0: a+b, 1: a-b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high while an operation is in flight
//   done   one-cycle pulse when out/c_out/ovf/zero are updated
//   out    result, held until the next operation completes
//   c_out  carry out of MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
//   zero   out == 0 (after any saturation)
//
// Build option:
//   SATURATE_EN  when defined, out clamps to the signed limit on overflow; ovf and c_out
//                still describe the unclamped result.

module add_seq #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = $clog2(N + 1);
    localparam int unsigned CW = CHUNK + 1;
    // k counts chunk cycles; k == N is the commit cycle.
    localparam logic [KW-1:0] KLast = KW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operands shift right by CHUNK each cycle so the active chunk is always at bit 0.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Result chunks are shifted in from the top; after N steps the LSB chunk sits at bit 0.
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic [KW-1:0]    k_q, k_d;

    logic [WIDTH-1:0] out_q, out_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

`ifdef SATURATE_EN
    // Sign of operand A decides the clamp direction.
    logic             sign_q, sign_d;
`endif

    logic [CW-1:0]    csum;
    logic             ovf_raw;
    logic [WIDTH-1:0] fin_out;

    always_comb begin
        csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + CW'(carry_q);
        // At commit, carry_q is the carry out of the MSB.
        ovf_raw = cmsb_q ^ carry_q;
`ifdef SATURATE_EN
        if (ovf_raw) begin
            fin_out = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_out = res_q;
        end
`else
        fin_out = res_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        k_d     = k_q;
        out_d   = out_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`ifdef SATURATE_EN
        sign_d  = sign_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    // Subtract as a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    k_d     = '0;
`ifdef SATURATE_EN
                    sign_d  = a[WIDTH-1];
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StDone;
                    out_d   = fin_out;
                    c_out_d = carry_q;
                    ovf_d   = ovf_raw;
                    zero_d  = (fin_out == '0);
                end else begin
                    a_d     = a_q >> CHUNK;
                    b_d     = b_q >> CHUNK;
                    res_d   = (res_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
                    carry_d = csum[CHUNK];
                    // Carry into this chunk's top bit; the value left after the last
                    // chunk is the carry into the word MSB.
                    cmsb_d  = csum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
                    k_d     = k_q + KW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            k_q     <= '0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SATURATE_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            k_q     <= k_d;
            out_q   <= out_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`ifdef SATURATE_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign out   = out_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule
